datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  Processor datapath driven directly by the control unit's outputs (D_addr, D_wr, RF_s, RF_W_*,
//  RF_Ra_*, RF_Rb_*, Alu_s0). Holds a 16x16 register file, a 256x16 synchronous data memory,
//  the write-back mux and the ALU. Produces ALU/register taps for display and a registered zero flag.
// PARAMETERS
//  DW      16   datapath / register / memory word width
//  RF_AW   4    register file address width (2**RF_AW registers)
//  DM_AW   8    data memory address width (2**DM_AW words)
// PORTS
//  Clock       in   1      system clock, all state updates on rising edge
//  Reset       in   1      synchronous, active-high
//  D_addr      in   DM_AW  data memory address
//  D_wr        in   1      data memory write enable
//  RF_s        in   1      write-back select: 1 = data memory q, 0 = ALU result
//  RF_W_addr   in   RF_AW  register file write address
//  RF_W_wr     in   1      register file write enable
//  RF_Ra_addr  in   RF_AW  read port A address
//  RF_Ra_rd    in   1      read port A enable
//  RF_Rb_addr  in   RF_AW  read port B address
//  RF_Rb_rd    in   1      read port B enable
//  Alu_s0      in   3      ALU operation select
//  Ra_data     out  DW     read port A value (ALU operand A, memory write data)
//  Rb_data     out  DW     read port B value (ALU operand B)
//  ALU_Out     out  DW     ALU result (combinational)
//  W_data      out  DW     write-back mux output
//  Zero        out  1      registered: last ALU write-back was zero
// BEHAVIOUR
//  Reset (sync): all 16 registers <= 0, Zero <= 0; data memory contents untouched; memory
//   writes and RF writes suppressed in the reset cycle (Reset wins over RF_W_wr and D_wr).
//  Register file: combinational reads; Ra_data = RF_Ra_rd ? R[RF_Ra_addr] : 0, same for B.
//   Write at edge when RF_W_wr: R[RF_W_addr] <= W_data. Read of register being written in the
//   same cycle returns OLD value; new value visible the following cycle. Ra==Rb addr legal.
//  Data memory: synchronous, 1-cycle read latency: q <= M[D_addr] every edge (read-before-write:
//   q shows old word if D_wr on same address). Write at edge when D_wr: M[D_addr] <= Ra_data.
//   Load therefore needs D_addr held one cycle before the cycle with RF_s=1, RF_W_wr=1.
//  Write-back mux: W_data = RF_s ? q : ALU_Out.
//  ALU (Alu_s0), results truncated mod 2**DW, no carry/overflow outputs:
//   000 0 | 001 A+B | 010 A-B | 011 A | 100 A^B | 101 A|B | 110 A&B | 111 A+1
//  Zero: on edge with RF_W_wr=1 and RF_s=0, Zero <= (ALU_Out==0); otherwise holds.
//  Outputs after reset: Ra_data/Rb_data = 0 (regs cleared), ALU_Out per select, Zero = 0.
//  Out-of-range addresses impossible (ports exactly sized); no X propagation allowed from
//   uninitialised memory into registers under test sequences that store before load.
// TESTING
//  1 Reset: write R3=0x1234, assert Reset 1 cycle -> R3 reads 0x0000, Zero=0; M[5] preserved.
//  2 Store/load: R1=0xBEEF, D_addr=0x10 D_wr=1 Ra=1; next D_addr=0x10; then RF_s=1 W=2 ->
//    R2=0xBEEF one cycle later.
//  3 ALU wrap: R1=0xFFFF R2=0x0001, Alu_s0=001 W=4 -> R4=0x0000, Zero=1; Alu_s0=010 (R2-R1)
//    -> 0x0002, Zero=0.
//  4 Same-cycle RAW: RF_W_wr to R7 with Ra=7 -> Ra_data old value that cycle, new value next.
//  5 Read enables low: RF_Ra_rd=RF_Rb_rd=0 with nonzero regs -> Ra_data=Rb_data=0, ALU 001 -> 0.
//  6 Reset collision: Reset=1 with RF_W_wr=1 and D_wr=1 -> no RF or memory write occurs.

Source files
------------

// File: rtl/datapath.sv
// Processor datapath: 16-entry register file, synchronous data memory,
// write-back mux, ALU and a registered zero flag, all driven by control-unit signals.
module datapath #(
    parameter int unsigned DW    = 16,
    parameter int unsigned RF_AW = 4,
    parameter int unsigned DM_AW = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DM_AW-1:0] D_addr,
    input  logic             D_wr,
    input  logic             RF_s,
    input  logic [RF_AW-1:0] RF_W_addr,
    input  logic             RF_W_wr,
    input  logic [RF_AW-1:0] RF_Ra_addr,
    input  logic             RF_Ra_rd,
    input  logic [RF_AW-1:0] RF_Rb_addr,
    input  logic             RF_Rb_rd,
    input  logic [2:0]       Alu_s0,
    output logic [DW-1:0]    Ra_data,
    output logic [DW-1:0]    Rb_data,
    output logic [DW-1:0]    ALU_Out,
    output logic [DW-1:0]    W_data,
    output logic             Zero
);

    localparam int unsigned RF_N = 1 << RF_AW;
    localparam int unsigned DM_N = 1 << DM_AW;

    logic [DW-1:0] rf  [RF_N];
    logic [DW-1:0] mem [DM_N];
    logic [DW-1:0] q;

    // Register file: reset clears every entry and blocks a coincident write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < RF_N; i++) begin
                rf[i] <= '0;
            end
        end else if (RF_W_wr) begin
            rf[RF_W_addr] <= W_data;
        end
    end

    assign Ra_data = RF_Ra_rd ? rf[RF_Ra_addr] : '0;
    assign Rb_data = RF_Rb_rd ? rf[RF_Rb_addr] : '0;

    // Data memory: read-before-write, contents survive reset
    always_ff @(posedge Clock) begin
        q <= mem[D_addr];
        if (D_wr && !Reset) begin
            mem[D_addr] <= Ra_data;
        end
    end

    always_comb begin
        ALU_Out = '0;
        case (Alu_s0)
            3'b000:  ALU_Out = '0;
            3'b001:  ALU_Out = Ra_data + Rb_data;
            3'b010:  ALU_Out = Ra_data - Rb_data;
            3'b011:  ALU_Out = Ra_data;
            3'b100:  ALU_Out = Ra_data ^ Rb_data;
            3'b101:  ALU_Out = Ra_data | Rb_data;
            3'b110:  ALU_Out = Ra_data & Rb_data;
            3'b111:  ALU_Out = Ra_data + DW'(1);
            default: ALU_Out = '0;
        endcase
    end

    assign W_data = RF_s ? q : ALU_Out;

    // Zero tracks only ALU write-backs; loads leave it unchanged
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Zero <= 1'b0;
        end else if (RF_W_wr && !RF_s) begin
            Zero <= (ALU_Out == '0);
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: expected values queued at stimulus time,
// popped and compared when the DUT output is observed.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic        RF_Ra_rd;
    logic [3:0]  RF_Rb_addr;
    logic        RF_Rb_rd;
    logic [2:0]  Alu_s0;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic [15:0] ALU_Out;
    logic [15:0] W_data;
    logic        Zero;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb_q[$];

    datapath dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Ra_rd   (RF_Ra_rd),
        .RF_Rb_addr (RF_Rb_addr),
        .RF_Rb_rd   (RF_Rb_rd),
        .Alu_s0     (Alu_s0),
        .Ra_data    (Ra_data),
        .Rb_data    (Rb_data),
        .ALU_Out    (ALU_Out),
        .W_data     (W_data),
        .Zero       (Zero)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        D_wr = 1'b0; RF_s = 1'b0; RF_W_wr = 1'b0;
        RF_Ra_rd = 1'b0; RF_Rb_rd = 1'b0; Alu_s0 = 3'b000;
    endtask

    // One ALU write-back cycle: R[w] <= op(R[a], R[b])
    task automatic alu_op(input logic [2:0] op, input logic [3:0] w,
                          input logic [3:0] a, input logic [3:0] b);
        Alu_s0 = op; RF_Ra_addr = a; RF_Rb_addr = b;
        RF_Ra_rd = 1'b1; RF_Rb_rd = 1'b1;
        RF_W_addr = w; RF_W_wr = 1'b1; RF_s = 1'b0;
        tick();
        idle();
    endtask

    // Build a constant in register r by shift-and-add from zero
    task automatic load_const(input logic [3:0] r, input logic [15:0] val);
        alu_op(3'b000, r, r, r);
        for (int i = 15; i >= 0; i--) begin
            alu_op(3'b001, r, r, r);
            if (val[i]) alu_op(3'b111, r, r, r);
        end
    endtask

    task automatic rd_a(input logic [3:0] a, output logic [15:0] v);
        RF_Ra_addr = a; RF_Ra_rd = 1'b1;
        #1;
        v = Ra_data;
        RF_Ra_rd = 1'b0;
    endtask

    task automatic store(input logic [3:0] a, input logic [7:0] addr);
        RF_Ra_addr = a; RF_Ra_rd = 1'b1; D_addr = addr; D_wr = 1'b1;
        tick();
        idle();
    endtask

    // Two-cycle load: address held one cycle, then write-back of q
    task automatic load(input logic [3:0] w, input logic [7:0] addr);
        D_addr = addr;
        tick();
        RF_s = 1'b1; RF_W_addr = w; RF_W_wr = 1'b1;
        tick();
        idle();
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a;
            3'b100:  return a ^ b;
            3'b101:  return a | b;
            3'b110:  return a & b;
            3'b111:  return a + 16'd1;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic test_reset();
        logic [15:0] obs, exp;
        load_const(4'd3, 16'h1234);
        store(4'd3, 8'h05);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb_q.push_back(16'h0000);
        rd_a(4'd3, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_r3 got %h want %h", obs, exp); end
        tests++;
        if (Zero !== 1'b0) begin fails++; $display("FAIL reset_zero got %b want 0", Zero); end
        D_addr = 8'h05;
        tick();
        RF_s = 1'b1;
        sb_q.push_back(16'h1234);
        #1;
        exp = sb_q.pop_front();
        tests++;
        if (W_data !== exp) begin fails++; $display("FAIL reset_mem_q got %h want %h", W_data, exp); end
        idle();
        load(4'd6, 8'h05);
        sb_q.push_back(16'h1234);
        rd_a(4'd6, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL reset_mem_kept got %h want %h", obs, exp); end
    endtask

    task automatic test_store_load();
        logic [15:0] obs, exp;
        load_const(4'd1, 16'hBEEF);
        store(4'd1, 8'h10);
        sb_q.push_back(16'hBEEF);
        load(4'd2, 8'h10);
        rd_a(4'd2, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL store_load got %h want %h", obs, exp); end
    endtask

    task automatic test_alu_wrap();
        logic [15:0] obs, exp;
        load_const(4'd1, 16'hFFFF);
        load_const(4'd2, 16'h0001);
        Alu_s0 = 3'b001; RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd2;
        RF_Ra_rd = 1'b1; RF_Rb_rd = 1'b1;
        sb_q.push_back(16'h0000);
        #1;
        exp = sb_q.pop_front();
        tests++;
        if (ALU_Out !== exp) begin fails++; $display("FAIL wrap_add_alu got %h want %h", ALU_Out, exp); end
        idle();
        alu_op(3'b001, 4'd4, 4'd1, 4'd2);
        sb_q.push_back(16'h0000);
        rd_a(4'd4, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL wrap_add_r4 got %h want %h", obs, exp); end
        tests++;
        if (Zero !== 1'b1) begin fails++; $display("FAIL wrap_add_zero got %b want 1", Zero); end
        alu_op(3'b010, 4'd5, 4'd2, 4'd1);
        sb_q.push_back(16'h0002);
        rd_a(4'd5, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL wrap_sub_r5 got %h want %h", obs, exp); end
        tests++;
        if (Zero !== 1'b0) begin fails++; $display("FAIL wrap_sub_zero got %b want 0", Zero); end
    endtask

    task automatic test_alu_ops();
        logic [15:0] exp;
        logic [2:0]  op;
        load_const(4'd12, 16'hA5C3);
        load_const(4'd13, 16'h3C0F);
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            Alu_s0 = op; RF_Ra_addr = 4'd12; RF_Rb_addr = 4'd13;
            RF_Ra_rd = 1'b1; RF_Rb_rd = 1'b1;
            sb_q.push_back(alu_model(op, 16'hA5C3, 16'h3C0F));
            #1;
            exp = sb_q.pop_front();
            tests++;
            if (ALU_Out !== exp) begin
                fails++; $display("FAIL alu_op%0d got %h want %h", i, ALU_Out, exp);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        load_const(4'd7, 16'h0011);
        Alu_s0 = 3'b111; RF_Ra_addr = 4'd7; RF_Ra_rd = 1'b1;
        RF_W_addr = 4'd7; RF_W_wr = 1'b1; RF_s = 1'b0;
        sb_q.push_back(16'h0011);
        sb_q.push_back(16'h0012);
        #1;
        exp = sb_q.pop_front();
        tests++;
        if (Ra_data !== exp) begin fails++; $display("FAIL raw_old got %h want %h", Ra_data, exp); end
        tick();
        RF_W_wr = 1'b0;
        #1;
        exp = sb_q.pop_front();
        tests++;
        if (Ra_data !== exp) begin fails++; $display("FAIL raw_new got %h want %h", Ra_data, exp); end
        idle();
    endtask

    task automatic test_read_enable();
        logic [15:0] exp;
        Alu_s0 = 3'b001; RF_Ra_addr = 4'd12; RF_Rb_addr = 4'd13;
        RF_Ra_rd = 1'b0; RF_Rb_rd = 1'b0;
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0000);
        #1;
        exp = sb_q.pop_front();
        tests++;
        if (Ra_data !== exp) begin fails++; $display("FAIL rden_a got %h want %h", Ra_data, exp); end
        exp = sb_q.pop_front();
        tests++;
        if (Rb_data !== exp) begin fails++; $display("FAIL rden_b got %h want %h", Rb_data, exp); end
        exp = sb_q.pop_front();
        tests++;
        if (ALU_Out !== exp) begin fails++; $display("FAIL rden_alu got %h want %h", ALU_Out, exp); end
        idle();
    endtask

    task automatic test_reset_collision();
        logic [15:0] obs, exp;
        load_const(4'd8, 16'h5555);
        store(4'd8, 8'h20);
        load_const(4'd9, 16'h7777);
        Reset = 1'b1;
        Alu_s0 = 3'b011; RF_Ra_addr = 4'd9; RF_Ra_rd = 1'b1;
        RF_W_addr = 4'd10; RF_W_wr = 1'b1; RF_s = 1'b0;
        D_addr = 8'h20; D_wr = 1'b1;
        tick();
        Reset = 1'b0;
        idle();
        sb_q.push_back(16'h0000);
        rd_a(4'd10, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL coll_rf got %h want %h", obs, exp); end
        tests++;
        if (Zero !== 1'b0) begin fails++; $display("FAIL coll_zero got %b want 0", Zero); end
        load(4'd11, 8'h20);
        sb_q.push_back(16'h5555);
        rd_a(4'd11, obs);
        exp = sb_q.pop_front();
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL coll_mem got %h want %h", obs, exp); end
    endtask

    initial begin
        Reset = 1'b1; D_addr = '0; RF_W_addr = '0; RF_Ra_addr = '0; RF_Rb_addr = '0;
        idle();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        test_reset();
        test_store_load();
        test_alu_wrap();
        test_alu_ops();
        test_back_to_back();
        test_read_enable();
        test_reset_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
